// File: rtl/bomber_pkg.sv
// Shared types and timing constants for the bomber game logic.
package bomber_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ALIVE     = 2'd1,
        INVUL     = 2'd2,
        GAME_OVER = 2'd3
    } life_state_t;

    localparam int FRAME_RATE = 30;

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter: load/clear act next cycle, decrements once per tick, holds at 0.
// done flags that the next tick ends the window (count == 1).
module frame_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // load beats tick so a window armed on a frame strobe starts at its full length
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/player_life_manager.sv
// Player lives, post-hit invulnerability/blink and game-over tracking; all outputs registered, 1-cycle hit latency.
// Define PLAYER_EXTRA_LIFE_EN to let extra_life_pulse add saturating bonus lives.
module player_life_manager
    import bomber_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int MAX_LIVES    = 7,
    parameter int LIVES_W      = 3,
    parameter int INVUL_FRAMES = 2 * FRAME_RATE,
    parameter int BLINK_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               hit_pulse,
    input  logic               game_start,
    input  logic               extra_life_pulse,
    output logic [LIVES_W-1:0] lives,
    output logic               invulnerable,
    output logic               player_visible,
    output logic               hit_ack,
    output logic               game_over,
    output logic               playing
);

    localparam int CNT_W   = $clog2(INVUL_FRAMES + 1);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [LIVES_W-1:0] LIVES_INIT_V = LIVES_W'(LIVES_INIT);
    localparam logic [LIVES_W-1:0] MAX_LIVES_V  = LIVES_W'(MAX_LIVES);
    localparam logic [CNT_W-1:0]   INVUL_LOAD   = CNT_W'(INVUL_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(BLINK_FRAMES - 1);

    life_state_t        state;
    logic [BLINK_W-1:0] blink_cnt;
    logic               bonus;
    logic               hit_to_over;
    logic [LIVES_W-1:0] lives_plus;
    logic [LIVES_W-1:0] lives_hit;
    logic               timer_load;
    logic               timer_done;

`ifdef PLAYER_EXTRA_LIFE_EN
    assign bonus = extra_life_pulse;
`else
    logic unused_extra_life;
    assign unused_extra_life = extra_life_pulse;
    assign bonus = 1'b0;
`endif

    // a bonus arriving with a hit cancels it, so the last life is kept and the player goes invulnerable
    always_comb begin
        hit_to_over = (lives == LIVES_W'(1)) && !bonus;
        lives_plus  = (bonus && (lives != MAX_LIVES_V)) ? lives + LIVES_W'(1) : lives;
        lives_hit   = bonus ? lives : lives - LIVES_W'(1);
        timer_load  = (state == ALIVE) && hit_pulse && !game_start && !hit_to_over;
    end

    frame_timer #(
        .CNT_W(CNT_W)
    ) u_invul_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (game_start),
        .load    (timer_load),
        .load_val(INVUL_LOAD),
        .tick    (startOfFrame),
        .done    (timer_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            lives          <= '0;
            blink_cnt      <= '0;
            invulnerable   <= 1'b0;
            player_visible <= 1'b0;
            hit_ack        <= 1'b0;
            game_over      <= 1'b0;
            playing        <= 1'b0;
        end else begin
            hit_ack <= 1'b0;
            if (game_start) begin
                state          <= ALIVE;
                lives          <= LIVES_INIT_V;
                blink_cnt      <= '0;
                invulnerable   <= 1'b0;
                player_visible <= 1'b1;
                game_over      <= 1'b0;
                playing        <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    ALIVE: begin
                        if (hit_pulse) begin
                            hit_ack        <= 1'b1;
                            player_visible <= 1'b0;
                            if (hit_to_over) begin
                                state     <= GAME_OVER;
                                lives     <= '0;
                                game_over <= 1'b1;
                                playing   <= 1'b0;
                            end else begin
                                state        <= INVUL;
                                lives        <= lives_hit;
                                blink_cnt    <= '0;
                                invulnerable <= 1'b1;
                            end
                        end else begin
                            lives <= lives_plus;
                        end
                    end
                    INVUL: begin
                        lives <= lives_plus;
                        if (startOfFrame) begin
                            if (timer_done) begin
                                state          <= ALIVE;
                                blink_cnt      <= '0;
                                invulnerable   <= 1'b0;
                                player_visible <= 1'b1;
                            end else if (blink_cnt == BLINK_LAST) begin
                                blink_cnt      <= '0;
                                player_visible <= !player_visible;
                            end else begin
                                blink_cnt <= blink_cnt + BLINK_W'(1);
                            end
                        end
                    end
                    GAME_OVER: begin
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_life_manager.sv
// Bench for player_life_manager: directed scenarios plus random traffic against a frame-count reference model.
module tb_player_life_manager;

    localparam int LIVES_INIT   = 3;
    localparam int MAX_LIVES    = 7;
    localparam int LIVES_W      = 3;
    localparam int INVUL_FRAMES = 60;
    localparam int BLINK_FRAMES = 4;
`ifdef PLAYER_EXTRA_LIFE_EN
    localparam bit EXTRA_EN = 1'b1;
`else
    localparam bit EXTRA_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_ALIVE = 1;
    localparam int M_INVUL = 2;
    localparam int M_OVER  = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               startOfFrame;
    logic               hit_pulse;
    logic               game_start;
    logic               extra_life_pulse;
    logic [LIVES_W-1:0] lives;
    logic               invulnerable;
    logic               player_visible;
    logic               hit_ack;
    logic               game_over;
    logic               playing;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mode;
    int m_lives;
    int m_elapsed;
    int m_ack;

    always #5 clk = ~clk;

    player_life_manager #(
        .LIVES_INIT  (LIVES_INIT),
        .MAX_LIVES   (MAX_LIVES),
        .LIVES_W     (LIVES_W),
        .INVUL_FRAMES(INVUL_FRAMES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .hit_pulse       (hit_pulse),
        .game_start      (game_start),
        .extra_life_pulse(extra_life_pulse),
        .lives           (lives),
        .invulnerable    (invulnerable),
        .player_visible  (player_visible),
        .hit_ack         (hit_ack),
        .game_over       (game_over),
        .playing         (playing)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: visibility is a function of frames elapsed since the hit.
    function automatic int exp_visible();
        if (m_mode == M_ALIVE) return 1;
        if (m_mode == M_INVUL) return (m_elapsed / BLINK_FRAMES) % 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_lives   = 0;
        m_elapsed = 0;
        m_ack     = 0;
    endtask

    task automatic model_step(input bit sof, input bit hit, input bit gs, input bit xl);
        bit bonus;
        bonus = xl & EXTRA_EN;
        m_ack = 0;
        if (gs) begin
            m_mode    = M_ALIVE;
            m_lives   = LIVES_INIT;
            m_elapsed = 0;
        end else if (m_mode == M_ALIVE && hit) begin
            m_ack   = 1;
            m_lives = m_lives - 1 + (bonus ? 1 : 0);
            if (m_lives == 0) begin
                m_mode = M_OVER;
            end else begin
                m_mode    = M_INVUL;
                m_elapsed = 0;
            end
        end else begin
            if ((m_mode == M_ALIVE || m_mode == M_INVUL) && bonus && m_lives < MAX_LIVES)
                m_lives++;
            if (m_mode == M_INVUL && sof) begin
                m_elapsed++;
                if (m_elapsed >= INVUL_FRAMES) m_mode = M_ALIVE;
            end
        end
    endtask

    task automatic compare_all();
        check("lives",        lives,          m_lives);
        check("invulnerable", invulnerable,   (m_mode == M_INVUL) ? 1 : 0);
        check("visible",      player_visible, exp_visible());
        check("hit_ack",      hit_ack,        m_ack);
        check("game_over",    game_over,      (m_mode == M_OVER) ? 1 : 0);
        check("playing",      playing,        (m_mode == M_ALIVE || m_mode == M_INVUL) ? 1 : 0);
    endtask

    task automatic step(input bit sof, input bit hit, input bit gs, input bit xl);
        @(negedge clk);
        startOfFrame     = sof;
        hit_pulse        = hit;
        game_start       = gs;
        extra_life_pulse = xl;
        @(posedge clk);
        model_step(sof, hit, gs, xl);
        #1;
        compare_all();
    endtask

    task automatic run_frames(input int n, input bit with_hits);
        for (int f = 0; f < n; f++) begin
            step(1'b1, with_hits, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset            = 1'b1;
        startOfFrame     = 1'b0;
        hit_pulse        = 1'b0;
        game_start       = 1'b0;
        extra_life_pulse = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        // start, first hit, blink cadence with hits ignored during the window
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("start_lives", lives, 3);
        check("start_playing", playing, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("hit1_ack", hit_ack, 1);
        check("hit1_lives", lives, 2);
        for (int f = 1; f <= INVUL_FRAMES; f++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (f == 4) check("vis_after4", player_visible, 1);
            if (f == 8) check("vis_after8", player_visible, 0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (f < INVUL_FRAMES) check("invul_no_ack", hit_ack, 0);
        end

        // hit and frame strobe together, then restart while a hit is pending
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("sof_hit_lives", lives, 1);
        run_frames(INVUL_FRAMES, 1'b0);
        check("back_alive", invulnerable, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("gs_hit_lives", lives, 3);
        check("gs_hit_noack", hit_ack, 0);

        // three hits to game over, hits ignored there, restart
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            run_frames(INVUL_FRAMES, 1'b0);
        end
        check("over_flag", game_over, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("over_noack", hit_ack, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("restart_over", game_over, 0);

`ifdef PLAYER_EXTRA_LIFE_EN
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("extra_sat", lives, MAX_LIVES);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("extra_hit_max", lives, MAX_LIVES);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            run_frames(INVUL_FRAMES, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("extra_last_lives", lives, 1);
        check("extra_last_invul", invulnerable, 1);
        check("extra_last_ack", hit_ack, 1);
`endif

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            step(($urandom % 3) == 0, ($urandom % 6) == 0,
                 ($urandom % 150) == 0, ($urandom % 10) == 0);
        end

        // mid-game asynchronous reset
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        startOfFrame = 1'b0;
        hit_pulse    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("idle_ignores_hit", lives, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
